load_store_unit: RTL and testbench

- Memory stage directly downstream of the execute ALU in the RV64 core.
- Takes the ALU result as effective address, or as the pass-through value for non-memory ops.
- For loads/stores, runs one 64-bit bus transaction: byte-lane steering, write masking, load sign/zero extension, bus-timeout detection.
- Presents one registered writeback record per accepted instruction.

---
 rtl/load_store_unit_if.sv | 41 ++++
 rtl/load_store_unit.sv | 220 ++++++++++++++++++++++
 tb/tb_load_store_unit.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/load_store_unit_if.sv
// Execute-to-memory handshake plus the 64-bit data bus seen by the load/store unit.
// slave is the LSU side; master is the surrounding pipeline/bus environment.
interface load_store_unit_if;
  logic        valid_in;
  logic        ready_out;
  logic [63:0] alu_result_in;
  logic [63:0] rs2_value_in;
  logic        mem_read_in;
  logic        mem_write_in;
  logic [1:0]  width_in;
  logic        zero_extend_in;
  logic [4:0]  rd_in;
  logic [63:0] bus_address_out;
  logic        bus_read_out;
  logic        bus_write_out;
  logic [7:0]  bus_write_mask_out;
  logic [63:0] bus_write_data_out;
  logic [63:0] bus_read_data_in;
  logic        bus_ack_in;
  logic        wb_valid_out;
  logic        wb_write_out;
  logic [4:0]  wb_rd_out;
  logic [63:0] wb_value_out;
  logic [1:0]  wb_fault_out;

  modport slave (
    input  valid_in, alu_result_in, rs2_value_in, mem_read_in, mem_write_in,
           width_in, zero_extend_in, rd_in, bus_read_data_in, bus_ack_in,
    output ready_out, bus_address_out, bus_read_out, bus_write_out,
           bus_write_mask_out, bus_write_data_out, wb_valid_out, wb_write_out,
           wb_rd_out, wb_value_out, wb_fault_out
  );

  modport master (
    output valid_in, alu_result_in, rs2_value_in, mem_read_in, mem_write_in,
           width_in, zero_extend_in, rd_in, bus_read_data_in, bus_ack_in,
    input  ready_out, bus_address_out, bus_read_out, bus_write_out,
           bus_write_mask_out, bus_write_data_out, wb_valid_out, wb_write_out,
           wb_rd_out, wb_value_out, wb_fault_out
  );
endinterface

// File: rtl/load_store_unit.sv
// RV64 memory stage: non-mem ops write back next cycle, loads/stores wb at ack+2; ready only in IDLE.
// LSU_MISALIGN_TRAP_EN: misaligned accesses trap (fault 01) instead of being force-aligned.
module load_store_unit #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input logic              clk,
  input logic              reset,
  load_store_unit_if.slave lsu
);
  localparam int unsigned CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, BUS_WAIT, RESP} state_t;

  state_t        state_q, state_d;
  logic [2:0]    off_q, off_d;
  logic [1:0]    width_q, width_d;
  logic [4:0]    rd_q, rd_d;
  logic          zext_q, zext_d;
  logic          store_q, store_d;
  logic [63:0]   rdata_q, rdata_d;
  logic [1:0]    fault_q, fault_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [63:0]   bus_addr_q, bus_addr_d;
  logic          bus_read_q, bus_read_d;
  logic          bus_write_q, bus_write_d;
  logic [7:0]    bus_mask_q, bus_mask_d;
  logic [63:0]   bus_wdata_q, bus_wdata_d;
  logic          wb_valid_q, wb_valid_d;
  logic          wb_write_q, wb_write_d;
  logic [4:0]    wb_rd_q, wb_rd_d;
  logic [63:0]   wb_value_q, wb_value_d;
  logic [1:0]    wb_fault_q, wb_fault_d;

  logic [2:0]    align_bits;
  logic [2:0]    eff_off;
  logic [7:0]    mask_base;
  logic [7:0]    mask_in;
  logic [63:0]   wdata_in;
  logic [63:0]   shifted;
  logic [63:0]   load_val;
  logic          is_mem;
  logic          timeout_hit;
`ifdef LSU_MISALIGN_TRAP_EN
  logic          misaligned;
`endif

  // Per-width lane pattern and the low offset bits that must be zero for alignment.
  always_comb begin
    align_bits = 3'b000;
    mask_base  = 8'h01;
    wdata_in   = {8{lsu.rs2_value_in[7:0]}};
    case (lsu.width_in)
      2'b00: begin align_bits = 3'b000; mask_base = 8'h01; wdata_in = {8{lsu.rs2_value_in[7:0]}}; end
      2'b01: begin align_bits = 3'b001; mask_base = 8'h03; wdata_in = {4{lsu.rs2_value_in[15:0]}}; end
      2'b10: begin align_bits = 3'b011; mask_base = 8'h0F; wdata_in = {2{lsu.rs2_value_in[31:0]}}; end
      default: begin align_bits = 3'b111; mask_base = 8'hFF; wdata_in = lsu.rs2_value_in; end
    endcase
    eff_off = lsu.alu_result_in[2:0] & ~align_bits;
    mask_in = mask_base << eff_off;
  end

`ifdef LSU_MISALIGN_TRAP_EN
  assign misaligned = |(lsu.alu_result_in[2:0] & align_bits);
`endif

  assign is_mem      = lsu.mem_read_in | lsu.mem_write_in;
  assign timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt_q == CNT_LAST);
  assign shifted     = rdata_q >> {off_q, 3'b000};

  always_comb begin
    load_val = shifted;
    case (width_q)
      2'b00:   load_val = zext_q ? {56'd0, shifted[7:0]}  : {{56{shifted[7]}},  shifted[7:0]};
      2'b01:   load_val = zext_q ? {48'd0, shifted[15:0]} : {{48{shifted[15]}}, shifted[15:0]};
      2'b10:   load_val = zext_q ? {32'd0, shifted[31:0]} : {{32{shifted[31]}}, shifted[31:0]};
      default: load_val = shifted;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    off_d       = off_q;
    width_d     = width_q;
    rd_d        = rd_q;
    zext_d      = zext_q;
    store_d     = store_q;
    rdata_d     = rdata_q;
    fault_d     = fault_q;
    cnt_d       = cnt_q;
    bus_addr_d  = bus_addr_q;
    bus_read_d  = bus_read_q;
    bus_write_d = bus_write_q;
    bus_mask_d  = bus_mask_q;
    bus_wdata_d = bus_wdata_q;
    // Writeback record is a pulse; fields read as zero whenever it is not valid.
    wb_valid_d  = 1'b0;
    wb_write_d  = 1'b0;
    wb_rd_d     = 5'd0;
    wb_value_d  = 64'd0;
    wb_fault_d  = 2'b00;

    case (state_q)
      IDLE: begin
        if (lsu.valid_in) begin
          if (!is_mem) begin
            wb_valid_d = 1'b1;
            wb_write_d = (lsu.rd_in != 5'd0);
            wb_rd_d    = lsu.rd_in;
            wb_value_d = lsu.alu_result_in;
          end
`ifdef LSU_MISALIGN_TRAP_EN
          else if (misaligned) begin
            wb_valid_d = 1'b1;
            wb_rd_d    = lsu.rd_in;
            wb_value_d = lsu.alu_result_in;
            wb_fault_d = 2'b01;
          end
`endif
          else begin
            off_d       = eff_off;
            width_d     = lsu.width_in;
            rd_d        = lsu.rd_in;
            zext_d      = lsu.zero_extend_in;
            store_d     = lsu.mem_write_in;
            fault_d     = 2'b00;
            cnt_d       = '0;
            bus_addr_d  = {lsu.alu_result_in[63:3], 3'b000};
            bus_read_d  = lsu.mem_read_in;
            bus_write_d = lsu.mem_write_in;
            bus_mask_d  = mask_in;
            bus_wdata_d = wdata_in;
            state_d     = BUS_WAIT;
          end
        end
      end
      BUS_WAIT: begin
        cnt_d = cnt_q + CW'(1);
        // An ack on the timeout cycle still completes the access cleanly.
        if (lsu.bus_ack_in || timeout_hit) begin
          rdata_d     = lsu.bus_read_data_in;
          fault_d     = lsu.bus_ack_in ? 2'b00 : 2'b10;
          bus_addr_d  = 64'd0;
          bus_read_d  = 1'b0;
          bus_write_d = 1'b0;
          bus_mask_d  = 8'd0;
          bus_wdata_d = 64'd0;
          state_d     = RESP;
        end
      end
      RESP: begin
        wb_valid_d = 1'b1;
        wb_rd_d    = rd_q;
        wb_fault_d = fault_q;
        if (fault_q == 2'b00 && !store_q) begin
          wb_write_d = (rd_q != 5'd0);
          wb_value_d = load_val;
        end
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      off_q       <= 3'd0;
      width_q     <= 2'd0;
      rd_q        <= 5'd0;
      zext_q      <= 1'b0;
      store_q     <= 1'b0;
      rdata_q     <= 64'd0;
      fault_q     <= 2'b00;
      cnt_q       <= '0;
      bus_addr_q  <= 64'd0;
      bus_read_q  <= 1'b0;
      bus_write_q <= 1'b0;
      bus_mask_q  <= 8'd0;
      bus_wdata_q <= 64'd0;
      wb_valid_q  <= 1'b0;
      wb_write_q  <= 1'b0;
      wb_rd_q     <= 5'd0;
      wb_value_q  <= 64'd0;
      wb_fault_q  <= 2'b00;
    end else begin
      state_q     <= state_d;
      off_q       <= off_d;
      width_q     <= width_d;
      rd_q        <= rd_d;
      zext_q      <= zext_d;
      store_q     <= store_d;
      rdata_q     <= rdata_d;
      fault_q     <= fault_d;
      cnt_q       <= cnt_d;
      bus_addr_q  <= bus_addr_d;
      bus_read_q  <= bus_read_d;
      bus_write_q <= bus_write_d;
      bus_mask_q  <= bus_mask_d;
      bus_wdata_q <= bus_wdata_d;
      wb_valid_q  <= wb_valid_d;
      wb_write_q  <= wb_write_d;
      wb_rd_q     <= wb_rd_d;
      wb_value_q  <= wb_value_d;
      wb_fault_q  <= wb_fault_d;
    end
  end

  assign lsu.ready_out          = (state_q == IDLE);
  assign lsu.bus_address_out    = bus_addr_q;
  assign lsu.bus_read_out       = bus_read_q;
  assign lsu.bus_write_out      = bus_write_q;
  assign lsu.bus_write_mask_out = bus_mask_q;
  assign lsu.bus_write_data_out = bus_wdata_q;
  assign lsu.wb_valid_out       = wb_valid_q;
  assign lsu.wb_write_out       = wb_write_q;
  assign lsu.wb_rd_out          = wb_rd_q;
  assign lsu.wb_value_out       = wb_value_q;
  assign lsu.wb_fault_out       = wb_fault_q;
endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with TIMEOUT_CYCLES=4; expectations adapt to LSU_MISALIGN_TRAP_EN.
module tb_load_store_unit;
  logic clk;
  logic reset;
  int   n_checks;
  int   n_errors;

  load_store_unit_if lsu_if ();

  load_store_unit #(.TIMEOUT_CYCLES(4)) dut (
    .clk   (clk),
    .reset (reset),
    .lsu   (lsu_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one cycle and land 1ns after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Offer one instruction for a single cycle; returns in the cycle after acceptance.
  task automatic issue(input logic rd_en, input logic wr_en, input logic [1:0] w,
                       input logic z, input logic [63:0] a, input logic [63:0] d,
                       input logic [4:0] r);
    lsu_if.valid_in       = 1'b1;
    lsu_if.mem_read_in    = rd_en;
    lsu_if.mem_write_in   = wr_en;
    lsu_if.width_in       = w;
    lsu_if.zero_extend_in = z;
    lsu_if.alu_result_in  = a;
    lsu_if.rs2_value_in   = d;
    lsu_if.rd_in          = r;
    step();
    lsu_if.valid_in     = 1'b0;
    lsu_if.mem_read_in  = 1'b0;
    lsu_if.mem_write_in = 1'b0;
  endtask

  // Ack in the current cycle, then step through RESP into the writeback cycle.
  task automatic ack_now(input logic [63:0] data);
    lsu_if.bus_ack_in       = 1'b1;
    lsu_if.bus_read_data_in = data;
    step();
    lsu_if.bus_ack_in       = 1'b0;
    lsu_if.bus_read_data_in = 64'd0;
    check("req_drop_after_ack", {62'd0, lsu_if.bus_read_out, lsu_if.bus_write_out}, 64'd0);
    step();
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    reset = 1'b1;
    lsu_if.valid_in         = 1'b0;
    lsu_if.alu_result_in    = 64'd0;
    lsu_if.rs2_value_in     = 64'd0;
    lsu_if.mem_read_in      = 1'b0;
    lsu_if.mem_write_in     = 1'b0;
    lsu_if.width_in         = 2'b00;
    lsu_if.zero_extend_in   = 1'b0;
    lsu_if.rd_in            = 5'd0;
    lsu_if.bus_read_data_in = 64'd0;
    lsu_if.bus_ack_in       = 1'b0;
    step();
    step();
    check("rst_ready", {63'd0, lsu_if.ready_out}, 64'd1);
    check("rst_wb_valid", {63'd0, lsu_if.wb_valid_out}, 64'd0);
    check("rst_bus_read", {63'd0, lsu_if.bus_read_out}, 64'd0);
    check("rst_bus_addr", lsu_if.bus_address_out, 64'd0);
    reset = 1'b0;
    step();

    // Non-memory ops, back to back
    issue(1'b0, 1'b0, 2'b11, 1'b0, 64'h1234, 64'd0, 5'd5);
    check("nm_wb_valid", {63'd0, lsu_if.wb_valid_out}, 64'd1);
    check("nm_wb_value", lsu_if.wb_value_out, 64'h1234);
    check("nm_wb_write", {63'd0, lsu_if.wb_write_out}, 64'd1);
    check("nm_wb_rd", {59'd0, lsu_if.wb_rd_out}, 64'd5);
    issue(1'b0, 1'b0, 2'b11, 1'b0, 64'h99, 64'd0, 5'd0);
    check("nm_rd0_valid", {63'd0, lsu_if.wb_valid_out}, 64'd1);
    check("nm_rd0_write", {63'd0, lsu_if.wb_write_out}, 64'd0);
    check("nm_rd0_value", lsu_if.wb_value_out, 64'h99);
    step();
    check("nm_idle_valid", {63'd0, lsu_if.wb_valid_out}, 64'd0);
    check("nm_idle_value", lsu_if.wb_value_out, 64'd0);

    // LB at 0x1003, ack on the second request cycle
    issue(1'b1, 1'b0, 2'b00, 1'b0, 64'h1003, 64'd0, 5'd7);
    check("lb_bus_read", {63'd0, lsu_if.bus_read_out}, 64'd1);
    check("lb_bus_addr", lsu_if.bus_address_out, 64'h1000);
    check("lb_ready_low", {63'd0, lsu_if.ready_out}, 64'd0);
    check("lb_no_wb", {63'd0, lsu_if.wb_valid_out}, 64'd0);
    step();
    check("lb_hold_read", {63'd0, lsu_if.bus_read_out}, 64'd1);
    ack_now(64'h00000000_80000000);
    check("lb_wb_valid", {63'd0, lsu_if.wb_valid_out}, 64'd1);
    check("lb_wb_value", lsu_if.wb_value_out, 64'hFFFFFFFF_FFFFFF80);
    check("lb_wb_write", {63'd0, lsu_if.wb_write_out}, 64'd1);
    check("lb_wb_rd", {59'd0, lsu_if.wb_rd_out}, 64'd7);
    check("lb_wb_fault", {62'd0, lsu_if.wb_fault_out}, 64'd0);
    check("lb_ready_back", {63'd0, lsu_if.ready_out}, 64'd1);

    // LBU, ack in the first request cycle: wb three cycles after accept
    issue(1'b1, 1'b0, 2'b00, 1'b1, 64'h1003, 64'd0, 5'd8);
    ack_now(64'h00000000_80000000);
    check("lbu_wb_valid", {63'd0, lsu_if.wb_valid_out}, 64'd1);
    check("lbu_wb_value", lsu_if.wb_value_out, 64'h80);

    // LH at 0x5006 picks the top halfword and sign-extends
    issue(1'b1, 1'b0, 2'b01, 1'b0, 64'h5006, 64'd0, 5'd10);
    check("lh_bus_addr", lsu_if.bus_address_out, 64'h5000);
    ack_now(64'h8123_0000_0000_0000);
    check("lh_wb_value", lsu_if.wb_value_out, 64'hFFFFFFFF_FFFF8123);

    // SH at 0x2006
    issue(1'b0, 1'b1, 2'b01, 1'b0, 64'h2006, 64'hABCD, 5'd4);
    check("sh_bus_write", {63'd0, lsu_if.bus_write_out}, 64'd1);
    check("sh_bus_read", {63'd0, lsu_if.bus_read_out}, 64'd0);
    check("sh_bus_addr", lsu_if.bus_address_out, 64'h2000);
    check("sh_mask", {56'd0, lsu_if.bus_write_mask_out}, 64'hC0);
    check("sh_wdata", lsu_if.bus_write_data_out, 64'hABCDABCD_ABCDABCD);
    step();
    check("sh_mask_hold", {56'd0, lsu_if.bus_write_mask_out}, 64'hC0);
    ack_now(64'hFFFF_FFFF_FFFF_FFFF);
    check("sh_wb_valid", {63'd0, lsu_if.wb_valid_out}, 64'd1);
    check("sh_wb_write", {63'd0, lsu_if.wb_write_out}, 64'd0);
    check("sh_wb_value", lsu_if.wb_value_out, 64'd0);

    // SB at 0x6005
    issue(1'b0, 1'b1, 2'b00, 1'b0, 64'h6005, 64'h12345677, 5'd0);
    check("sb_mask", {56'd0, lsu_if.bus_write_mask_out}, 64'h20);
    check("sb_wdata", lsu_if.bus_write_data_out, 64'h77777777_77777777);
    ack_now(64'd0);

    // Double load with no ack: timeout after four BUS_WAIT cycles
    issue(1'b1, 1'b0, 2'b11, 1'b0, 64'h4000, 64'd0, 5'd9);
    for (int i = 0; i < 4; i++) begin
      check("to_req_held", {63'd0, lsu_if.bus_read_out}, 64'd1);
      check("to_ready_low", {63'd0, lsu_if.ready_out}, 64'd0);
      step();
    end
    check("to_req_dropped", {63'd0, lsu_if.bus_read_out}, 64'd0);
    check("to_resp_ready", {63'd0, lsu_if.ready_out}, 64'd0);
    step();
    check("to_wb_valid", {63'd0, lsu_if.wb_valid_out}, 64'd1);
    check("to_wb_fault", {62'd0, lsu_if.wb_fault_out}, 64'd2);
    check("to_wb_write", {63'd0, lsu_if.wb_write_out}, 64'd0);
    check("to_ready_back", {63'd0, lsu_if.ready_out}, 64'd1);

    // LW at 0x3002
    issue(1'b1, 1'b0, 2'b10, 1'b0, 64'h3002, 64'd0, 5'd6);
`ifdef LSU_MISALIGN_TRAP_EN
    check("lw_mis_no_req", {63'd0, lsu_if.bus_read_out}, 64'd0);
    check("lw_mis_wb_valid", {63'd0, lsu_if.wb_valid_out}, 64'd1);
    check("lw_mis_fault", {62'd0, lsu_if.wb_fault_out}, 64'd1);
    check("lw_mis_value", lsu_if.wb_value_out, 64'h3002);
    check("lw_mis_write", {63'd0, lsu_if.wb_write_out}, 64'd0);
    check("lw_mis_ready", {63'd0, lsu_if.ready_out}, 64'd1);
`else
    check("lw_al_req", {63'd0, lsu_if.bus_read_out}, 64'd1);
    check("lw_al_addr", lsu_if.bus_address_out, 64'h3000);
    check("lw_al_mask", {56'd0, lsu_if.bus_write_mask_out}, 64'h0F);
    ack_now(64'h11223344_55667788);
    check("lw_al_value", lsu_if.wb_value_out, 64'h00000000_55667788);
    check("lw_al_fault", {62'd0, lsu_if.wb_fault_out}, 64'd0);
`endif
    step();

    // Reset during BUS_WAIT drops the request without a clock edge
    issue(1'b1, 1'b0, 2'b11, 1'b0, 64'h7000, 64'd0, 5'd2);
    check("rb_req_before", {63'd0, lsu_if.bus_read_out}, 64'd1);
    #2 reset = 1'b1;
    #1;
    check("rb_req_async_drop", {63'd0, lsu_if.bus_read_out}, 64'd0);
    #1 reset = 1'b0;
    step();
    for (int i = 0; i < 3; i++) begin
      check("rb_no_wb", {63'd0, lsu_if.wb_valid_out}, 64'd0);
      step();
    end
    check("rb_ready", {63'd0, lsu_if.ready_out}, 64'd1);
    issue(1'b0, 1'b0, 2'b00, 1'b0, 64'hBEEF, 64'd0, 5'd3);
    check("rb_next_valid", {63'd0, lsu_if.wb_valid_out}, 64'd1);
    check("rb_next_value", lsu_if.wb_value_out, 64'hBEEF);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
